// File: rtl/rv32_wb_stage_unit.sv
// rv32_wb_stage_unit: registered RV32 writeback stage.
// Selects one of six writeback sources and registers it together with the
// destination register and write enable. A load whose data has not arrived
// holds the stage in WAIT_LU and stalls upstream. Flush drops the incoming
// instruction and aborts a held load wait. Writes to x0 are suppressed.
// Optional feature macro WB_PERF_EN adds retire and load-wait counters.
module rv32_wb_stage_unit #(
  parameter int XLEN      = 32,
  parameter int SEL_W     = 3,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 valid_in,
  input  logic                 flush_in,
  input  logic [SEL_W-1:0]     wb_mux_sel_in,
  input  logic [RF_ADDR_W-1:0] rd_addr_in,
  input  logic                 rf_we_in,
  input  logic [XLEN-1:0]      alu_result_in,
  input  logic [XLEN-1:0]      lu_output_in,
  input  logic                 lu_valid_in,
  input  logic [XLEN-1:0]      imm_in,
  input  logic [XLEN-1:0]      csr_data_in,
  input  logic [XLEN-1:0]      pc_plus_4_in,
  input  logic [XLEN-1:0]      iaddr_out_in,
  output logic [XLEN-1:0]      wb_data_out,
  output logic [RF_ADDR_W-1:0] wb_rd_out,
  output logic                 wb_we_out,
  output logic                 wb_valid_out,
  output logic                 stall_out
`ifdef WB_PERF_EN
  ,
  output logic [31:0]          retire_cnt_out,
  output logic [31:0]          lu_wait_cnt_out
`endif
);

  typedef enum logic {ST_RUN, ST_WAIT_LU} state_t;

  localparam logic [SEL_W-1:0] SEL_ALU   = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_LU    = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_IMM   = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_CSR   = SEL_W'(3);
  localparam logic [SEL_W-1:0] SEL_PC4   = SEL_W'(4);
  localparam logic [SEL_W-1:0] SEL_IADDR = SEL_W'(5);

  state_t                 state_q, state_d;
  logic [RF_ADDR_W-1:0]   hold_rd_q, hold_rd_d;
  logic                   hold_we_q, hold_we_d;
  logic [XLEN-1:0]        data_d;
  logic [RF_ADDR_W-1:0]   rd_d;
  logic                   we_d;
  logic                   valid_d;
  logic [XLEN-1:0]        sel_data;
  logic                   load_miss;

  // Writeback source mux; reserved selects fall back to the ALU result.
  always_comb begin
    unique case (wb_mux_sel_in)
      SEL_LU:    sel_data = lu_output_in;
      SEL_IMM:   sel_data = imm_in;
      SEL_CSR:   sel_data = csr_data_in;
      SEL_PC4:   sel_data = pc_plus_4_in;
      SEL_IADDR: sel_data = iaddr_out_in;
      default:   sel_data = alu_result_in;
    endcase
  end

  // A load is issued in RUN but its data is not ready yet.
  assign load_miss = valid_in && !flush_in && (wb_mux_sel_in == SEL_LU) && !lu_valid_in;

  // State register.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_in) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Next-state logic; flush always returns to RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:     if (load_miss) state_d = ST_WAIT_LU;
      ST_WAIT_LU: if (flush_in || lu_valid_in) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  // Output/hold-register next values; data and rd hold when nothing retires.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    data_d    = wb_data_out;
    rd_d      = wb_rd_out;
    we_d      = 1'b0;
    valid_d   = 1'b0;
    hold_rd_d = hold_rd_q;
    hold_we_d = hold_we_q;
    if (!flush_in) begin
      unique case (state_q)
        ST_RUN: begin
          if (load_miss) begin
            hold_rd_d = rd_addr_in;
            hold_we_d = rf_we_in;
          end else if (valid_in) begin
            data_d  = sel_data;
            rd_d    = rd_addr_in;
            we_d    = rf_we_in && (rd_addr_in != '0);
            valid_d = 1'b1;
          end
        end
        ST_WAIT_LU: begin
          if (lu_valid_in) begin
            data_d  = lu_output_in;
            rd_d    = hold_rd_q;
            we_d    = hold_we_q && (hold_rd_q != '0);
            valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output and hold registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wb_data_out  <= '0;
      wb_rd_out    <= '0;
      wb_we_out    <= 1'b0;
      wb_valid_out <= 1'b0;
      hold_rd_q    <= '0;
      hold_we_q    <= 1'b0;
    end else begin
      wb_data_out  <= data_d;
      wb_rd_out    <= rd_d;
      wb_we_out    <= we_d;
      wb_valid_out <= valid_d;
      hold_rd_q    <= hold_rd_d;
      hold_we_q    <= hold_we_d;
    end
  end

  assign stall_out = (state_q == ST_WAIT_LU);

`ifdef WB_PERF_EN
  // Performance counters; wrap naturally and ignore flush.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      retire_cnt_out  <= '0;
      lu_wait_cnt_out <= '0;
    end else begin
      if (valid_d)                 retire_cnt_out  <= retire_cnt_out + 32'd1;
      if (state_q == ST_WAIT_LU)   lu_wait_cnt_out <= lu_wait_cnt_out + 32'd1;
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: doc/rv32_wb_stage_unit.md
Name: rv32_wb_stage_unit

Overview:
Registered writeback stage for the RV32 pipeline, parametrised in data width.
- Selects the writeback value from six sources (ALU, load unit, immediate, CSR, PC+4, iaddr_out) and registers it with the destination register and write enable for the register file.
- Adds a load-wait handshake: if the load unit has not produced data, the stage holds the instruction and stalls upstream.
- Adds flush handling and x0 write suppression.

Parameters:
- XLEN, 32, data width of all source and result buses.
- SEL_W, 3, width of the writeback select field.
- RF_ADDR_W, 5, register-file address width.

Ports:
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- valid_in  input  1  an instruction is presented on the inputs this cycle.
- flush_in  input  1  kill the incoming instruction and any held load wait.
- wb_mux_sel_in  input  SEL_W  select: 0 ALU, 1 LU, 2 IMM, 3 CSR, 4 PC_PLUS, 5 IADDR_OUT, 6/7 reserved.
- rd_addr_in  input  RF_ADDR_W  destination register.
- rf_we_in  input  1  instruction writes the register file.
- alu_result_in  input  XLEN  ALU result.
- lu_output_in  input  XLEN  load-unit data.
- lu_valid_in  input  1  lu_output_in is valid this cycle.
- imm_in  input  XLEN  immediate.
- csr_data_in  input  XLEN  CSR read data.
- pc_plus_4_in  input  XLEN  PC+4.
- iaddr_out_in  input  XLEN  computed instruction address.
- wb_data_out  output  XLEN  registered writeback data.
- wb_rd_out  output  RF_ADDR_W  registered destination.
- wb_we_out  output  1  registered register-file write enable.
- wb_valid_out  output  1  registered: a retired instruction is presented this cycle.
- stall_out  output  1  upstream must hold all inputs.

Behaviour:
- Reset (rst_in=1 at an edge): state=RUN; wb_data_out=0, wb_rd_out=0, wb_we_out=0, wb_valid_out=0; stall_out=0. Reset overrides all other inputs, including mid-WAIT_LU.
- stall_out is 1 exactly when state==WAIT_LU.
- State RUN, valid_in=1, flush_in=0:
  - sel!=LU, or sel==LU with lu_valid_in=1: at the next edge, register the selected data, rd, we and valid=1. Latency 1 cycle. State stays RUN.
  - sel==LU with lu_valid_in=0: capture rd and we into hold registers; state→WAIT_LU. Outputs at that edge: wb_valid_out=0, wb_we_out=0.
- State RUN, valid_in=0: at the next edge, wb_valid_out=0 and wb_we_out=0; wb_data_out and wb_rd_out hold their last values.
- State WAIT_LU:
  - valid_in, wb_mux_sel_in and the other instruction inputs are ignored; upstream holds them.
  - lu_valid_in=1: at the next edge, wb_data_out=lu_output_in, wb_rd_out/wb_we_out come from the hold registers, wb_valid_out=1, state→RUN. stall_out falls in the following cycle; the held upstream instruction is accepted in that cycle.
  - lu_valid_in=0: wb_valid_out=0 and wb_we_out=0 each cycle; remain in WAIT_LU indefinitely (no timeout).
- flush_in=1, either state: at the next edge, state→RUN, wb_valid_out=0, wb_we_out=0; the incoming instruction is dropped and any held load wait is aborted. flush_in wins over a simultaneous lu_valid_in.
- x0 suppression: wb_we_out = rf_we & (rd!=0). wb_valid_out is still 1 for the retired instruction.
- Reserved sel values 6/7 select ALU data.
- All data is passed through unmodified at XLEN width; no arithmetic.

Optional Feature:
Macro WB_PERF_EN.
- Defined: adds two outputs, retire_cnt_out[31:0] and lu_wait_cnt_out[31:0]; both reset to 0.
  - retire_cnt_out increments on each edge that sets wb_valid_out=1.
  - lu_wait_cnt_out increments on each cycle spent in WAIT_LU.
  - Both wrap 0xFFFFFFFF→0 and are not cleared by flush_in.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Reset then ALU op: valid_in=1, sel=0, alu_result_in=0x1234_5678, rd=5, we=1 → next cycle wb_data_out=0x12345678, wb_rd_out=5, wb_we_out=1, wb_valid_out=1, stall_out=0.
- Sweep sel=1..5 with distinct source values (LU with lu_valid_in=1) → each value appears one cycle later. sel=6 and sel=7 → ALU value.
- Load wait: sel=1, rd=7, lu_valid_in=0 for 3 cycles, then 1 with lu_output_in=0xDEAD_BEEF:
  - stall_out high for 4 cycles.
  - wb_valid_out=1 with data 0xDEADBEEF, rd=7 on the cycle after lu_valid_in.
  - With WB_PERF_EN: lu_wait_cnt_out=4.
- Flush during WAIT_LU: flush_in=1 together with lu_valid_in=1 → no write (wb_we_out=0, wb_valid_out=0); stall_out=0 next cycle.
- x0: rd=0, we=1, sel=0 → wb_we_out=0, wb_valid_out=1.
- Sync reset asserted mid-WAIT_LU → next cycle all outputs 0, stall_out=0. A later lu_valid_in pulse produces no write.
